kv_txn_scheduler: RTL and testbench

Front-end controller for the cuckoo-hashed key/value BRAM store (`create_bram`). It accepts search, credit and debit requests from `NUM_REQ` requesters and arbitrates among them round-robin. Each granted request is sequenced as a lookup followed, for credits and debits, by a conditional transact. Balance and overflow checks happen before the store is written, and one status-tagged response is returned per request.

---
 rtl/kv_pkg.sv | 32 +++
 rtl/kv_txn_scheduler_rr_arbiter.sv | 55 +++++
 rtl/kv_txn_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_kv_txn_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kv_pkg.sv
//------------------------------------------------------------------------------
// kv_pkg : shared encodings for the key/value transaction scheduler
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package kv_pkg;

    localparam logic [1:0] OP_SEARCH  = 2'd0;
    localparam logic [1:0] OP_CREDIT  = 2'd1;
    localparam logic [1:0] OP_DEBIT   = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [1:0] STS_OK        = 2'd0;
    localparam logic [1:0] STS_NOT_FOUND = 2'd1;
    localparam logic [1:0] STS_REJECT    = 2'd2;
    localparam logic [1:0] STS_OVERFLOW  = 2'd3;

    localparam logic [1:0] SIG_SEARCH   = 2'd0;
    localparam logic [1:0] SIG_TRANSACT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/kv_txn_scheduler_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, pointer advances past the accepted grant
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] C_LAST = IW'(NUM_REQ - 1);

    logic [IW-1:0] r_ptr;

    // First pass looks at or after the pointer, second pass wraps around.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i] && (IW'(i) >= r_ptr)) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(i);
                grant[i]    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(i);
                grant[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (enable && grant_valid) begin
            r_ptr <= (grant_idx == C_LAST) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/kv_txn_scheduler.sv
//------------------------------------------------------------------------------
// kv_txn_scheduler : arbitrates search/credit/debit requests onto the KV store
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module kv_txn_scheduler #(
    parameter int                    NUM_REQ        = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    STORE_LATENCY  = 4,
    parameter logic [DATA_WIDTH-1:0] NOT_FOUND_ADDR = '1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [2*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_key,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_amount,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [1:0]                    rsp_status,
    output logic [DATA_WIDTH-1:0]         rsp_value,
    output logic                          ram_enable,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         key,
    output logic [1:0]                    signal,
    output logic [DATA_WIDTH-1:0]         transact_value,
    output logic                          transact_kind,
    input  logic [DATA_WIDTH-1:0]         value_addr,
    input  logic [DATA_WIDTH-1:0]         updated_value,
    output logic                          busy
);

    import kv_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STORE_LATENCY + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(STORE_LATENCY - 1);

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  w_cnt_last, w_idle;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_grant_valid;
    logic [1:0]            w_sel_op;
    logic [DATA_WIDTH-1:0] w_sel_key, w_sel_amount;
    logic [IW-1:0]         r_id;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_key, r_amount, r_cur;
    logic                  r_not_found;
    logic [1:0]            w_chk_status;
    logic                  w_chk_commit, w_ovf;

    assign w_idle     = (r_state == S_IDLE);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);
    assign busy       = !w_idle;
    assign req_ready  = (reset_n && w_idle) ? w_grant : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (w_idle),
        .req         (req_valid),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    always_comb begin
        w_sel_op     = '0;
        w_sel_key    = '0;
        w_sel_amount = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op     = req_op[2*i +: 2];
                w_sel_key    = req_key[DATA_WIDTH*i +: DATA_WIDTH];
                w_sel_amount = req_amount[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // cur + amount overflows exactly when amount exceeds the headroom ~cur.
    assign w_ovf = (r_amount > ~r_cur);

    always_comb begin
        w_chk_status = STS_OK;
        w_chk_commit = 1'b0;
        if (r_op == OP_ILLEGAL)                             w_chk_status = STS_REJECT;
        else if (r_not_found)                               w_chk_status = STS_NOT_FOUND;
        else if (r_op == OP_SEARCH)                         w_chk_status = STS_OK;
        else if ((r_op == OP_DEBIT) && (r_amount > r_cur))  w_chk_status = STS_REJECT;
        else if ((r_op == OP_CREDIT) && w_ovf)              w_chk_status = STS_OVERFLOW;
        else                                                w_chk_commit = 1'b1;
    end

    always_comb begin
        w_next         = r_state;
        ram_enable     = 1'b0;
        write_enable   = 1'b0;
        key            = '0;
        signal         = SIG_SEARCH;
        transact_value = '0;
        transact_kind  = 1'b0;
        case (r_state)
            S_IDLE:   if (w_grant_valid) w_next = S_LOOKUP;
            S_LOOKUP: begin
                ram_enable = 1'b1;
                key        = r_key;
                if (w_cnt_last) w_next = S_CHECK;
            end
            S_CHECK:  w_next = w_chk_commit ? S_COMMIT : S_RESP;
            S_COMMIT: begin
                ram_enable     = 1'b1;
                write_enable   = 1'b1;
                key            = r_key;
                signal         = SIG_TRANSACT;
                transact_value = r_amount;
                transact_kind  = (r_op == OP_CREDIT);
                if (w_cnt_last) w_next = S_RESP;
            end
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_key       <= '0;
            r_amount    <= '0;
            r_cur       <= '0;
            r_not_found <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_status  <= '0;
            rsp_value   <= '0;
        end else begin
            if (r_state != w_next)
                r_cnt <= '0;
            else if ((r_state == S_LOOKUP) || (r_state == S_COMMIT))
                r_cnt <= r_cnt + CW'(1);

            if (w_idle && w_grant_valid) begin
                r_id     <= w_grant_idx;
                r_op     <= w_sel_op;
                r_key    <= w_sel_key;
                r_amount <= w_sel_amount;
            end

            if ((r_state == S_LOOKUP) && w_cnt_last) begin
                r_cur       <= updated_value;
                r_not_found <= (value_addr == NOT_FOUND_ADDR);
            end

            if ((r_state == S_CHECK) && !w_chk_commit) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= r_id;
                rsp_status <= w_chk_status;
                rsp_value  <= r_cur;
            end else if ((r_state == S_COMMIT) && w_cnt_last) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= r_id;
                rsp_status <= STS_OK;
                rsp_value  <= updated_value;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kv_txn_scheduler.sv
//------------------------------------------------------------------------------
// tb_kv_txn_scheduler : directed self-checking bench with a small store model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_kv_txn_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [2*N-1:0]    req_op = '0;
    logic [DW*N-1:0]   req_key = '0;
    logic [DW*N-1:0]   req_amount = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [1:0]        rsp_status;
    logic [DW-1:0]     rsp_value;
    logic              ram_enable, write_enable, transact_kind, busy;
    logic [DW-1:0]     key, transact_value, value_addr, updated_value;
    logic [1:0]        signal;

    always #5 clock = ~clock;

    kv_txn_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .STORE_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_status(rsp_status), .rsp_value(rsp_value),
        .ram_enable(ram_enable), .write_enable(write_enable), .key(key),
        .signal(signal), .transact_value(transact_value), .transact_kind(transact_kind),
        .value_addr(value_addr), .updated_value(updated_value), .busy(busy)
    );

    // Store model: key 249 and key 300 present, everything else absent.
    logic [DW-1:0] m249 = 32'd500;
    logic [DW-1:0] m300 = 32'h200;
    logic [DW-1:0] cur;
    int            wcnt;

    always_comb begin
        value_addr = '1;
        cur        = '0;
        if (key == 32'd249) begin
            value_addr = 32'd5;
            cur        = m249;
        end else if (key == 32'd300) begin
            value_addr = 32'd9;
            cur        = m300;
        end
        updated_value = cur;
        if (signal == 2'd2)
            updated_value = transact_kind ? cur + transact_value : cur - transact_value;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= 0;
        end else if (write_enable) begin
            if (wcnt == L - 1) begin
                wcnt <= 0;
                if (key == 32'd249) m249 <= updated_value;
                if (key == 32'd300) m300 <= updated_value;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    int            we_cycles = 0;
    logic          last_kind = 1'b0;
    logic [DW-1:0] last_tval = '0;

    always @(negedge clock) begin
        if (write_enable) begin
            we_cycles <= we_cycles + 1;
            last_kind <= transact_kind;
            last_tval <= transact_value;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic run_txn(input int id, input logic [1:0] op, input logic [DW-1:0] k,
                           input logic [DW-1:0] amt, output int lat, output int we_n);
        int n;
        int we0;
        @(negedge clock);
        req_op[2*id +: 2]      = op;
        req_key[DW*id +: DW]    = k;
        req_amount[DW*id +: DW] = amt;
        req_valid[id]           = 1'b1;
        rsp_ready               = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check_eq("grant", 64'(req_ready[id]), 64'd1);
        we0 = we_cycles;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            req_valid[id] = 1'b0;
        end while (!rsp_valid && lat < 40);
        #1;
        we_n = we_cycles - we0;
    endtask

    int lat, we_n;
    int gq[$];
    int rq[$];
    int rem[N];
    int stall, nrsp, stable_errs, val_errs, n;
    logic [N-1:0]  clr;
    logic [1:0]    h_id, h_st;
    logic [DW-1:0] h_val;

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ram_enable", 64'(ram_enable), 64'd0);
        check_eq("rst_rsp_value", 64'(rsp_value), 64'd0);
        reset_n = 1'b1;

        run_txn(0, 2'd0, 32'd249, 32'd0, lat, we_n);
        check_eq("search_lat", 64'(lat), 64'd6);
        check_eq("search_status", 64'(rsp_status), 64'd0);
        check_eq("search_value", 64'(rsp_value), 64'd500);
        check_eq("search_id", 64'(rsp_id), 64'd0);
        check_eq("search_no_write", 64'(we_n), 64'd0);

        run_txn(1, 2'd1, 32'd249, 32'd100, lat, we_n);
        check_eq("credit_lat", 64'(lat), 64'd10);
        check_eq("credit_status", 64'(rsp_status), 64'd0);
        check_eq("credit_value", 64'(rsp_value), 64'd600);
        check_eq("credit_id", 64'(rsp_id), 64'd1);
        check_eq("credit_we_cycles", 64'(we_n), 64'd4);
        check_eq("credit_kind", 64'(last_kind), 64'd1);
        check_eq("credit_tval", 64'(last_tval), 64'd100);

        run_txn(2, 2'd2, 32'd249, 32'd700, lat, we_n);
        check_eq("debit_insuf_lat", 64'(lat), 64'd6);
        check_eq("debit_insuf_status", 64'(rsp_status), 64'd2);
        check_eq("debit_insuf_value", 64'(rsp_value), 64'd600);
        check_eq("debit_insuf_no_write", 64'(we_n), 64'd0);

        run_txn(3, 2'd0, 32'd77, 32'd0, lat, we_n);
        check_eq("absent_status", 64'(rsp_status), 64'd1);
        check_eq("absent_id", 64'(rsp_id), 64'd3);

        run_txn(0, 2'd1, 32'd300, 32'hFFFF_FF00, lat, we_n);
        check_eq("ovf_status", 64'(rsp_status), 64'd3);
        check_eq("ovf_value", 64'(rsp_value), 64'h200);
        check_eq("ovf_no_write", 64'(we_n), 64'd0);

        run_txn(1, 2'd3, 32'd249, 32'd1, lat, we_n);
        check_eq("illegal_status", 64'(rsp_status), 64'd2);
        check_eq("illegal_no_write", 64'(we_n), 64'd0);

        run_txn(2, 2'd2, 32'd249, 32'd100, lat, we_n);
        check_eq("debit_lat", 64'(lat), 64'd10);
        check_eq("debit_status", 64'(rsp_status), 64'd0);
        check_eq("debit_value", 64'(rsp_value), 64'd500);
        check_eq("debit_kind", 64'(last_kind), 64'd0);

        run_txn(3, 2'd0, 32'd249, 32'd0, lat, we_n);
        check_eq("search2_value", 64'(rsp_value), 64'd500);

        // All four requesters at once, requester 0 asks twice, responses stalled.
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]   = 2'd0;
            req_key[DW*i +: DW] = 32'd249;
        end
        rem = '{2, 1, 1, 1};
        req_valid = '1;
        clr = '0;
        stall = 0; nrsp = 0; stable_errs = 0; val_errs = 0;
        for (int cyc = 0; cyc < 400 && nrsp < 5; cyc++) begin
            @(negedge clock);
            req_valid = req_valid & ~clr;
            clr       = '0;
            rsp_ready = 1'b0;
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gq.push_back(i);
                    rem[i]--;
                    if (rem[i] == 0) clr[i] = 1'b1;
                end
            end
            if (rsp_valid) begin
                if (stall == 0) begin
                    h_id = rsp_id; h_st = rsp_status; h_val = rsp_value;
                end else if ({rsp_id, rsp_status, rsp_value} != {h_id, h_st, h_val}) begin
                    stable_errs++;
                end
                stall++;
                if (stall == 4) begin
                    rsp_ready = 1'b1;
                    stall = 0;
                    nrsp++;
                    rq.push_back(int'(rsp_id));
                    if (rsp_status != 2'd0 || rsp_value != 32'd500) val_errs++;
                end
            end
        end
        check_eq("rr_grant_count", 64'(gq.size()), 64'd5);
        check_eq("rr_rsp_count", 64'(rq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rr_grant%0d", i), 64'((i < gq.size()) ? gq[i] : -1), 64'(i % N));
            check_eq($sformatf("rr_rsp%0d", i), 64'((i < rq.size()) ? rq[i] : -1), 64'(i % N));
        end
        check_eq("rr_stall_stable", 64'(stable_errs), 64'd0);
        check_eq("rr_values", 64'(val_errs), 64'd0);

        // Reset in the middle of a commit.
        @(negedge clock);
        rsp_ready = 1'b1;
        req_op[2*1 +: 2]      = 2'd1;
        req_key[DW*1 +: DW]    = 32'd249;
        req_amount[DW*1 +: DW] = 32'd5;
        req_valid = 4'b0010;
        n = 0;
        #1;
        while (!write_enable && n < 30) begin
            @(negedge clock);
            req_valid = '0;
            #1;
            n++;
        end
        check_eq("abort_reached_commit", 64'(write_enable), 64'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("abort_ram_enable", 64'(ram_enable), 64'd0);
        check_eq("abort_write_enable", 64'(write_enable), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (rsp_valid) n++;
        end
        check_eq("abort_no_rsp", 64'(n), 64'd0);

        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]   = 2'd0;
            req_key[DW*i +: DW] = 32'd249;
        end
        req_valid = 4'b0101;
        #1;
        check_eq("post_reset_grant", 64'(req_ready), 64'b0001);
        @(negedge clock);
        req_valid = 4'b0000;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        #1;
        check_eq("post_reset_id", 64'(rsp_id), 64'd0);
        check_eq("post_reset_value", 64'(rsp_value), 64'd500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
